// File: rtl/rc4_encryptor.sv
// RC4 stream encryptor: KSA then PRGA over an external 256x8 S memory,
// XORing the keystream with MSG_LEN plaintext bytes into a ciphertext RAM.
// Memory address/data/wren outputs are decoded from the registered state so
// a read issued in one state returns its data in the next state.
module rc4_encryptor #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] key,
  output logic [7:0]  s_arr_addr,
  output logic [7:0]  s_arr_data,
  output logic        s_arr_wren,
  input  logic [7:0]  s_arr_q,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_q,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_data,
  output logic        ct_wren,
  output logic        ready,
  output logic        done
);

  localparam int unsigned DW     = 8;
  localparam int unsigned KW     = 24;
  localparam logic [DW-1:0] I_LAST = 8'hFF;
  localparam logic [DW-1:0] K_LAST = DW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, INIT,
    K_RD, K_GI, K_GJ, K_WJ,
    P_RD, P_GI, P_GJ, P_WJ, P_RF, P_GF,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] i_q, i_d;
  logic [DW-1:0] j_q, j_d;
  logic [DW-1:0] k_q, k_d;
  logic [1:0]    km_q, km_d;
  logic [DW-1:0] si_q, si_d;
  logic [DW-1:0] sj_q, sj_d;
  logic [KW-1:0] key_q, key_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;

  logic          accept;
  logic [DW-1:0] key_byte;

  assign ready = ready_q;
  assign done  = done_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      km_q    <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      km_q    <= km_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter updates and memory port decode
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    km_d       = km_q;
    si_d       = si_q;
    sj_d       = sj_q;
    key_d      = key_q;
    s_arr_addr = '0;
    s_arr_data = '0;
    s_arr_wren = 1'b0;
    pt_addr    = '0;
    ct_addr    = '0;
    ct_data    = '0;
    ct_wren    = 1'b0;
    accept     = start && ready_q;

    // key byte for i mod 3, tracked by a small wrapping counter
    case (km_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          km_d    = '0;
          state_d = INIT;
        end
      end

      INIT: begin
        s_arr_addr = i_q;
        s_arr_data = i_q;
        s_arr_wren = 1'b1;
        i_d        = i_q + 8'd1;
        if (i_q == I_LAST) begin
          j_d     = '0;
          km_d    = '0;
          state_d = K_RD;
        end
      end

      K_RD: begin
        s_arr_addr = i_q;
        state_d    = K_GI;
      end

      K_GI: begin
        si_d       = s_arr_q;
        j_d        = j_q + s_arr_q + key_byte;
        s_arr_addr = j_d;
        state_d    = K_GJ;
      end

      K_GJ: begin
        s_arr_addr = i_q;
        s_arr_data = s_arr_q;
        s_arr_wren = 1'b1;
        state_d    = K_WJ;
      end

      K_WJ: begin
        s_arr_addr = j_q;
        s_arr_data = si_q;
        s_arr_wren = 1'b1;
        i_d        = i_q + 8'd1;
        km_d       = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
        if (i_q == I_LAST) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = P_RD;
        end else begin
          state_d = K_RD;
        end
      end

      P_RD: begin
        pt_addr    = k_q;
        i_d        = i_q + 8'd1;
        s_arr_addr = i_d;
        state_d    = P_GI;
      end

      P_GI: begin
        pt_addr    = k_q;
        si_d       = s_arr_q;
        j_d        = j_q + s_arr_q;
        s_arr_addr = j_d;
        state_d    = P_GJ;
      end

      P_GJ: begin
        pt_addr    = k_q;
        sj_d       = s_arr_q;
        s_arr_addr = i_q;
        s_arr_data = s_arr_q;
        s_arr_wren = 1'b1;
        state_d    = P_WJ;
      end

      P_WJ: begin
        pt_addr    = k_q;
        s_arr_addr = j_q;
        s_arr_data = si_q;
        s_arr_wren = 1'b1;
        state_d    = P_RF;
      end

      P_RF: begin
        pt_addr    = k_q;
        s_arr_addr = si_q + sj_q;
        state_d    = P_GF;
      end

      P_GF: begin
        pt_addr = k_q;
        ct_addr = k_q;
        ct_data = s_arr_q ^ pt_q;
        ct_wren = 1'b1;
        k_d     = k_q + 8'd1;
        state_d = (k_q == K_LAST) ? DONE : P_RD;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == DONE);
    done_d  = (state_q == DONE) && !accept;
  end

endmodule

// File: tb/tb_rc4_encryptor.sv
// Bench for rc4_encryptor: three instances (MSG_LEN 9, 32, 1) with behavioural
// S, plaintext and ciphertext memories, directed vectors and an RC4 reference.
module tb_rc4_encryptor;

  localparam int unsigned N0 = 9;
  localparam int unsigned N1 = 32;
  localparam int unsigned N2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [23:0]      key;
  logic [2:0]       start;
  logic [2:0][7:0]  s_addr, s_data, s_q, pt_addr, pt_q, ct_addr, ct_data;
  logic [2:0]       s_wren, ct_wren, rdy, dn;

  logic [7:0] s_mem  [3][256];
  logic [7:0] pt_mem [3][256];
  logic [7:0] ct_mem [3][256];
  int         ct_cnt [3];
  int         s_cnt  [3];

  logic [7:0] ks   [256];
  logic [7:0] orig [256];
  logic [7:0] exp2 [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt2  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

  int n_cmp = 0;
  int n_bad = 0;

  rc4_encryptor #(.MSG_LEN(N0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .key(key),
    .s_arr_addr(s_addr[0]), .s_arr_data(s_data[0]), .s_arr_wren(s_wren[0]), .s_arr_q(s_q[0]),
    .pt_addr(pt_addr[0]), .pt_q(pt_q[0]),
    .ct_addr(ct_addr[0]), .ct_data(ct_data[0]), .ct_wren(ct_wren[0]),
    .ready(rdy[0]), .done(dn[0])
  );

  rc4_encryptor #(.MSG_LEN(N1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .key(key),
    .s_arr_addr(s_addr[1]), .s_arr_data(s_data[1]), .s_arr_wren(s_wren[1]), .s_arr_q(s_q[1]),
    .pt_addr(pt_addr[1]), .pt_q(pt_q[1]),
    .ct_addr(ct_addr[1]), .ct_data(ct_data[1]), .ct_wren(ct_wren[1]),
    .ready(rdy[1]), .done(dn[1])
  );

  rc4_encryptor #(.MSG_LEN(N2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .key(key),
    .s_arr_addr(s_addr[2]), .s_arr_data(s_data[2]), .s_arr_wren(s_wren[2]), .s_arr_q(s_q[2]),
    .pt_addr(pt_addr[2]), .pt_q(pt_q[2]),
    .ct_addr(ct_addr[2]), .ct_data(ct_data[2]), .ct_wren(ct_wren[2]),
    .ready(rdy[2]), .done(dn[2])
  );

  // Synchronous-read memories with one cycle of read latency, plus write counters
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (s_wren[d]) begin
        s_mem[d][s_addr[d]] <= s_data[d];
        s_cnt[d] <= s_cnt[d] + 1;
      end
      s_q[d]  <= s_mem[d][s_addr[d]];
      pt_q[d] <= pt_mem[d][pt_addr[d]];
      if (ct_wren[d]) begin
        ct_mem[d][ct_addr[d]] <= ct_data[d];
        ct_cnt[d] <= ct_cnt[d] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference RC4 keystream for a 3-byte key
  task automatic gen_ks(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t, f;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      j = j + s[x] + kb[x % 3];
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 8'd0;
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      f = s[i] + s[j];
      ks[x] = s[f];
    end
  endtask

  // Start a run on instance d; optional spurious start with a new key at cycle inj
  task automatic run(input int d, input logic [23:0] k, input int inj, output int lat);
    @(negedge clk);
    key      = k;
    start[d] = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 3000) begin
      @(negedge clk);
      start[d] = (inj != 0) && (lat == inj);
      if ((inj != 0) && (lat == inj)) key = 24'hFFFFFF;
      @(posedge clk);
      lat++;
      #1;
      if (dn[d]) break;
    end
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic check_idle(input int d, input string pfx);
    check_eq({pfx, "_ready"},   32'(rdy[d]),     32'd1);
    check_eq({pfx, "_done"},    32'(dn[d]),      32'd0);
    check_eq({pfx, "_s_wren"},  32'(s_wren[d]),  32'd0);
    check_eq({pfx, "_ct_wren"}, 32'(ct_wren[d]), 32'd0);
    check_eq({pfx, "_s_addr"},  32'(s_addr[d]),  32'd0);
    check_eq({pfx, "_pt_addr"}, 32'(pt_addr[d]), 32'd0);
    check_eq({pfx, "_ct_addr"}, 32'(ct_addr[d]), 32'd0);
  endtask

  initial begin
    int lat, c0, s0;
    reset = 1'b1;
    start = '0;
    key   = '0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_idle(d, $sformatf("rst%0d", d));
    @(negedge clk);
    reset = 1'b0;

    // 2: "Key" / "Plaintext" known-answer vector and latency
    for (int x = 0; x < 9; x++) pt_mem[0][x] = pt2[x];
    c0 = ct_cnt[0];
    s0 = s_cnt[0];
    run(0, 24'h4B6579, 0, lat);
    check_eq("kat_latency", 32'(lat), 32'd1335);
    check_eq("kat_ct_writes", 32'(ct_cnt[0] - c0), 32'd9);
    check_eq("kat_s_writes", 32'(s_cnt[0] - s0), 32'd786);
    check_eq("kat_ready", 32'(rdy[0]), 32'd1);
    for (int x = 0; x < 9; x++)
      check_eq($sformatf("kat_ct%0d", x), 32'(ct_mem[0][x]), 32'(exp2[x]));

    // 6: zero key, single byte
    pt_mem[2][0] = 8'h5A;
    c0 = ct_cnt[2];
    run(2, 24'h000000, 0, lat);
    check_eq("one_latency", 32'(lat), 32'd1287);
    check_eq("one_ct0", 32'(ct_mem[2][0]), 32'h84);
    repeat (5) @(posedge clk);
    #1;
    check_eq("one_ct_writes", 32'(ct_cnt[2] - c0), 32'd1);
    check_eq("one_hold_ready", 32'(rdy[2]), 32'd1);
    check_eq("one_hold_done", 32'(dn[2]), 32'd1);

    // 3: random round trip against the reference model
    for (int x = 0; x < 32; x++) begin
      orig[x] = 8'($urandom_range(0, 255));
      pt_mem[1][x] = orig[x];
    end
    gen_ks(24'h000123);
    c0 = ct_cnt[1];
    run(1, 24'h000123, 0, lat);
    check_eq("rt1_latency", 32'(lat), 32'd1473);
    check_eq("rt1_ct_writes", 32'(ct_cnt[1] - c0), 32'd32);
    for (int x = 0; x < 32; x++) begin
      check_eq($sformatf("rt1_ct%0d", x), 32'(ct_mem[1][x]), 32'(orig[x] ^ ks[x]));
      pt_mem[1][x] = ct_mem[1][x];
    end
    run(1, 24'h000123, 0, lat);
    check_eq("rt2_latency", 32'(lat), 32'd1473);
    for (int x = 0; x < 32; x++)
      check_eq($sformatf("rt2_pt%0d", x), 32'(ct_mem[1][x]), 32'(orig[x]));

    // 4: start with a new key mid-run is ignored
    for (int x = 0; x < 32; x++) pt_mem[1][x] = 8'(x * 7 + 3);
    gen_ks(24'h0A0B0C);
    run(1, 24'h0A0B0C, 100, lat);
    check_eq("busy_latency", 32'(lat), 32'd1473);
    for (int x = 0; x < 32; x++)
      check_eq($sformatf("busy_ct%0d", x), 32'(ct_mem[1][x]), 32'(8'(x * 7 + 3) ^ ks[x]));

    // 5: reset during KSA, then a clean rerun
    @(negedge clk);
    key      = 24'h123456;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (656) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle(1, "midrst");
    c0 = ct_cnt[1];
    s0 = s_cnt[1];
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_no_s_writes", 32'(s_cnt[1] - s0), 32'd0);
    check_eq("midrst_no_ct_writes", 32'(ct_cnt[1] - c0), 32'd0);
    check_eq("midrst_ready", 32'(rdy[1]), 32'd1);
    gen_ks(24'h123456);
    run(1, 24'h123456, 0, lat);
    check_eq("after_rst_latency", 32'(lat), 32'd1473);
    for (int x = 0; x < 32; x++)
      check_eq($sformatf("after_rst_ct%0d", x), 32'(ct_mem[1][x]), 32'(8'(x * 7 + 3) ^ ks[x]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
